// File: rtl/lcrc_rx_check.sv
// Receive-side LCRC and sequence checker: recomputes CRC-32 over a 96-bit TLP one byte per
// cycle, then issues an ACK/NAK toward the replay buffer and forwards good TLPs upstream.
module lcrc_rx_check #(
  parameter int unsigned SEQ_W    = 12,
  parameter int unsigned ERR_W    = 8,
  parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     frame_in,
  input  logic             frame_vld,
  output logic             frame_rdy,
  output logic [95:0]      tlp_o,
  output logic             tlp_vld,
  output logic             resp_vld,
  output logic             resp_ack,
  output logic [SEQ_W-1:0] resp_seq,
  input  logic             resp_rdy,
  output logic [SEQ_W-1:0] exp_seq,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [31:0] CrcPoly = 32'h04C11DB7;

  typedef enum logic [1:0] {StIdle, StCalc, StCheck, StResp} state_e;

  state_e           state_q;
  logic [127:0]     frame_q;
  logic [31:0]      crc_q;
  logic [3:0]       byte_cnt_q;
  logic             frame_rdy_q;
  logic [95:0]      tlp_q;
  logic             tlp_vld_q;
  logic             resp_vld_q;
  logic             resp_ack_q;
  logic [SEQ_W-1:0] resp_seq_q;
  logic [SEQ_W-1:0] exp_seq_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [6:0]       byte_idx;
  logic [31:0]      crc_next;
  logic [SEQ_W-1:0] rx_seq;
  logic             crc_ok;
  logic             seq_ok;

  // Non-reflected, MSB-first fold of one byte into the running CRC.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ data[i]) r = {r[30:0], 1'b0} ^ CrcPoly;
      else                 r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    // Byte 0 is TLP[95:88] = frame[127:120]; byte 11 is TLP[7:0] = frame[39:32].
    byte_idx = 7'(7'd127 - {byte_cnt_q, 3'b000});
    crc_next = crc_byte(crc_q, frame_q[byte_idx -: 8]);
    rx_seq   = frame_q[127 -: SEQ_W];
    crc_ok   = ((crc_q ^ 32'hFFFFFFFF) == frame_q[31:0]);
    seq_ok   = (rx_seq == exp_seq_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      frame_q     <= '0;
      crc_q       <= CRC_INIT;
      byte_cnt_q  <= '0;
      frame_rdy_q <= 1'b1;
      tlp_q       <= '0;
      tlp_vld_q   <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_ack_q  <= 1'b0;
      resp_seq_q  <= '0;
      exp_seq_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      tlp_vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_vld && frame_rdy_q) begin
            frame_q     <= frame_in;
            crc_q       <= CRC_INIT;
            byte_cnt_q  <= '0;
            frame_rdy_q <= 1'b0;
            state_q     <= StCalc;
          end
        end
        StCalc: begin
          crc_q      <= crc_next;
          byte_cnt_q <= byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd11) state_q <= StCheck;
        end
        StCheck: begin
          resp_vld_q <= 1'b1;
          state_q    <= StResp;
          if (crc_ok && seq_ok) begin
            resp_ack_q <= 1'b1;
            resp_seq_q <= rx_seq;
            tlp_q      <= frame_q[127:32];
            tlp_vld_q  <= 1'b1;
            exp_seq_q  <= exp_seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
          end else begin
            // NAK names the last sequence number that was accepted in order.
            resp_ack_q <= 1'b0;
            resp_seq_q <= exp_seq_q - {{(SEQ_W-1){1'b0}}, 1'b1};
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_q <= err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
          end
        end
        StResp: begin
          if (resp_rdy) begin
            resp_vld_q  <= 1'b0;
            frame_rdy_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frame_rdy = frame_rdy_q;
  assign tlp_o     = tlp_q;
  assign tlp_vld   = tlp_vld_q;
  assign resp_vld  = resp_vld_q;
  assign resp_ack  = resp_ack_q;
  assign resp_seq  = resp_seq_q;
  assign exp_seq   = exp_seq_q;
  assign err_cnt   = err_cnt_q;

endmodule
